// File: rtl/mult_defs_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM state encodings, datapath widths and a sign-extension helper.
package mult_defs;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 16;
    localparam int ACC_WIDTH  = 34;
    localparam int ITER_W     = $clog2(MULT_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    // Sign-extend an operand to accumulator width
    function automatic logic signed [ACC_WIDTH-1:0] sext_acc(
        input logic signed [MULT_WIDTH-1:0] v
    );
        return {{(ACC_WIDTH-MULT_WIDTH){v[MULT_WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/booth_radix4_select.sv
// Radix-4 Booth digit selector: decodes {m1,m0,guard} into a digit in
// {-2,-1,0,+1,+2} and returns digit*A at accumulator width.
module booth_radix4_select
    import mult_defs::*;
(
    input  logic        [2:0]            booth_bits,
    input  logic signed [MULT_WIDTH-1:0] multiplicand,
    output logic signed [ACC_WIDTH-1:0]  addend
);

    logic signed [ACC_WIDTH-1:0] a_ext;
    logic signed [ACC_WIDTH-1:0] a_dbl;

    assign a_ext = sext_acc(multiplicand);
    // 2*|A| <= 2^32 always fits in the 34-bit signed range
    assign a_dbl = a_ext <<< 1;

    // Map the three recoding bits to the signed multiple of A
    always_comb begin
        addend = '0;
        case (booth_bits)
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a_dbl;
            3'b100:         addend = -a_dbl;
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
    end

endmodule

// File: rtl/iterative_booth_multiplier.sv
// Iterative signed 32x32 multiplier, radix-4 Booth, one digit per cycle.
// A start is accepted in IDLE or DONE; 16 RUN cycles follow, then DONE
// registers the low product word and the overflow flag with a one-cycle
// data_resultRDY pulse.
// Build option: define MULT_SATURATE_EN to clamp data_result to the signed
// 32-bit limits on overflow (data_exception is the same in both builds).
module iterative_booth_multiplier
    import mult_defs::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ctrl_mult,
    input  logic [MULT_WIDTH-1:0] data_operandA,
    input  logic [MULT_WIDTH-1:0] data_operandB,
    output logic [MULT_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic                  busy
);

    mult_state_t state_q;
    mult_state_t state_d;

    logic [ITER_W-1:0]           iter_q;
    logic signed [MULT_WIDTH-1:0] a_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [MULT_WIDTH-1:0]        mult_q;
    logic                         guard_q;

    logic signed [ACC_WIDTH-1:0]  addend;
    logic signed [ACC_WIDTH-1:0]  acc_sum;

    logic start_accept;
    logic last_iter;
    logic load_en;
    logic step_en;
    logic capture_en;
    logic overflow;

`ifdef MULT_SATURATE_EN
    logic neg_q;

    // Clamp to the signed limit matching the true product sign on overflow
    function automatic logic [MULT_WIDTH-1:0] pick_result(
        input logic                  ovf,
        input logic                  neg,
        input logic [MULT_WIDTH-1:0] low
    );
        if (!ovf)
            return low;
        return neg ? {1'b1, {(MULT_WIDTH-1){1'b0}}}
                   : {1'b0, {(MULT_WIDTH-1){1'b1}}};
    endfunction
`else
    // Wrapping build: the low product word is returned as is
    function automatic logic [MULT_WIDTH-1:0] pick_result(
        input logic [MULT_WIDTH-1:0] low
    );
        return low;
    endfunction
`endif

    assign start_accept = ctrl_mult && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_iter    = (iter_q == ITER_W'(MULT_ITERS - 1));

    booth_radix4_select u_select (
        .booth_bits   ({mult_q[1:0], guard_q}),
        .multiplicand (a_q),
        .addend       (addend)
    );

    assign acc_sum = acc_q + addend;

    // Overflow when P[63:31] is not a pure sign run. P[63:32] is acc_q[31:0];
    // acc_q[33:32] are always copies of acc_q[31] at this point, so testing
    // the whole accumulator gives the same answer.
    assign overflow = !((&{acc_q, mult_q[MULT_WIDTH-1]}) ||
                        (~|{acc_q, mult_q[MULT_WIDTH-1]}));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic; ctrl_mult is ignored while running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ctrl_mult) state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ctrl_mult ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        busy       = (state_q == ST_RUN);
        load_en    = start_accept;
        step_en    = (state_q == ST_RUN);
        capture_en = (state_q == ST_DONE);
    end

    // Datapath: load operands on start, then one Booth step per RUN cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iter_q  <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            mult_q  <= '0;
            guard_q <= 1'b0;
        end else if (load_en) begin
            iter_q  <= '0;
            a_q     <= data_operandA;
            acc_q   <= '0;
            mult_q  <= data_operandB;
            guard_q <= 1'b0;
        end else if (step_en) begin
            iter_q  <= iter_q + 1'b1;
            acc_q   <= acc_sum >>> 2;
            mult_q  <= {acc_sum[1:0], mult_q[MULT_WIDTH-1:2]};
            guard_q <= mult_q[1];
        end
    end

`ifdef MULT_SATURATE_EN
    // Remember the expected product sign for the saturating result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            neg_q <= 1'b0;
        else if (load_en)
            neg_q <= data_operandA[MULT_WIDTH-1] ^ data_operandB[MULT_WIDTH-1];
    end
`endif

    // Result registers: updated once per operation in DONE, held otherwise
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= capture_en;
            if (capture_en) begin
`ifdef MULT_SATURATE_EN
                data_result <= pick_result(overflow, neg_q, mult_q);
`else
                data_result <= pick_result(mult_q);
`endif
                data_exception <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_iterative_booth_multiplier.sv
// Self-checking bench for iterative_booth_multiplier: directed corner cases,
// randomized operands, start-while-running, back-to-back restart and
// mid-operation reset, compared against a plain-arithmetic product model.
module tb_iterative_booth_multiplier;

    logic        clock;
    logic        reset_n;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int          c;
        logic [31:0] r;
        logic        e;
    } rdy_t;

    rdy_t rdy_q[$];

    iterative_booth_multiplier dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every ready pulse with the edge count it followed
    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            rdy_t t;
            t.c = cyc;
            t.r = data_result;
            t.e = data_exception;
            rdy_q.push_back(t);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: full signed product with 64-bit integer arithmetic
    function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic e);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        r = p[31:0];
`ifdef MULT_SATURATE_EN
        if (e)
            r = (a[31] ^ b[31]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    // One complete operation from IDLE, checking timing, hold and result
    task automatic single(input logic [31:0] a, input logic [31:0] b, input string tag);
        int          s;
        logic [31:0] er;
        logic [31:0] pr;
        logic        ee;
        logic        pe;
        ref_mul(a, b, er, ee);
        pr = data_result;
        pe = data_exception;
        ctrl_mult     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        s = cyc + 1;
        @(negedge clock);
        ctrl_mult     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        wait_cyc(s + 8);
        chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
        chk({tag, "_hold_mid"}, {31'd0, data_exception, data_result}, {31'd0, pe, pr});
        wait_cyc(s + 16);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        wait_cyc(s + 19);
        chk({tag, "_rdy_count"}, 64'(rdy_q.size()), 64'd1);
        if (rdy_q.size() >= 1) begin
            chk({tag, "_rdy_cycle"}, 64'(rdy_q[0].c), 64'(s + 17));
            chk({tag, "_result"}, 64'(rdy_q[0].r), 64'(er));
            chk({tag, "_exception"}, 64'(rdy_q[0].e), 64'(ee));
        end
        rdy_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          s;
        int          s2;

        reset_n       = 1'b0;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("rst_result", 64'(data_result), 64'd0);
        chk("rst_exception", 64'(data_exception), 64'd0);
        chk("rst_rdy", 64'(data_resultRDY), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        single(32'd7,          32'hFFFF_FFFD, "d_7xm3");
        single(32'h7FFF_FFFF,  32'd2,         "d_maxx2");
        single(32'h8000_0000,  32'hFFFF_FFFF, "d_minxm1");
        single(32'hFFFF_0000,  32'h0000_8000, "d_edge_min");
        single(32'h8000_0000,  32'h8000_0000, "d_minxmin");
        single(32'h0001_0000,  32'h0000_8000, "d_edge_pos");

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 4)
                1: b = $urandom_range(0, 255);
                2: begin
                    a = {{16{a[15]}}, a[15:0]};
                    b = {{16{b[15]}}, b[15:0]};
                end
                3: a = -a;
                default: ;
            endcase
            single(a, b, "rand");
        end

        // Start ignored while running, then back-to-back restart from DONE
        ctrl_mult     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd6;
        s = cyc + 1;
        @(negedge clock);
        ctrl_mult = 1'b0;
        wait_cyc(s + 4);
        ctrl_mult     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        ctrl_mult = 1'b0;
        wait_cyc(s + 16);
        ctrl_mult = 1'b1;
        s2 = cyc + 1;
        @(negedge clock);
        ctrl_mult = 1'b0;
        chk("rs_busy_restart", 64'(busy), 64'd1);
        wait_cyc(s2 + 8);
        chk("rs_hold", 64'(data_result), 64'd30);
        wait_cyc(s2 + 19);
        chk("rs_rdy_count", 64'(rdy_q.size()), 64'd2);
        if (rdy_q.size() >= 2) begin
            chk("rs_first_cycle", 64'(rdy_q[0].c), 64'(s + 17));
            chk("rs_first_result", 64'(rdy_q[0].r), 64'd30);
            chk("rs_second_cycle", 64'(rdy_q[1].c), 64'(s2 + 17));
            chk("rs_second_result", 64'(rdy_q[1].r), 64'd81);
            chk("rs_second_exc", 64'(rdy_q[1].e), 64'd0);
        end
        rdy_q.delete();

        // Reset in the middle of an operation aborts it silently
        ctrl_mult     = 1'b1;
        data_operandA = 32'h0BAD_F00D;
        data_operandB = 32'h7654_3210;
        s = cyc + 1;
        @(negedge clock);
        ctrl_mult = 1'b0;
        wait_cyc(s + 8);
        reset_n = 1'b0;
        #1;
        chk("ab_result", 64'(data_result), 64'd0);
        chk("ab_exception", 64'(data_exception), 64'd0);
        chk("ab_rdy", 64'(data_resultRDY), 64'd0);
        chk("ab_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (25) @(negedge clock);
        chk("ab_no_rdy", 64'(rdy_q.size()), 64'd0);
        chk("ab_busy_after", 64'(busy), 64'd0);
        rdy_q.delete();

        single(32'h1234_5678, 32'd0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
